// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: one load/store at a time, programmable
// wait states, byte/half/word access on a word-organised RAM, and a
// sign/zero-extended registered load result.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  // Counter preload; unused when there are no wait states.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        done_d, err_d, accept, fault;

  // Request fields captured on the accepting edge.
  logic                  l_we, l_se;
  logic [1:0]            l_size;
  logic [ADDR_WIDTH+1:0] l_addr;
  logic [31:0]           l_wdata;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           word, wd_al, ld;
  logic [3:0]            be;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  // Upper address bits are ignored, so the RAM aliases modulo its size.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign busy = (state != IDLE);

  // Misaligned halves/words and the reserved size code are rejected up front.
  always_comb begin
    fault = (size == 2'b11) ||
            (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
  end

  // Next-state and completion decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (fault) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            accept = 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_d = ACCESS;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = ACCESS;
        else             cnt_d   = cnt - 4'd1;
      end
      ACCESS: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      done     <= done_d;
      addr_err <= err_d;
    end
  end

  // Capture the request; later input changes are don't-care.
  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= we;
      l_se    <= sign_ext;
      l_size  <= size;
      l_addr  <= addr[ADDR_WIDTH+1:0];
      l_wdata <= wdata;
    end
  end

  assign idx  = l_addr[ADDR_WIDTH+1:2];
  assign lane = l_addr[1:0];
  assign word = mem[idx];

  // Lane enables and replicated store data so any enabled lane sees its bytes.
  always_comb begin
    case (l_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wd_al = {4{l_wdata[7:0]}};
      end
      2'b01: begin
        be    = l_addr[1] ? 4'b1100 : 4'b0011;
        wd_al = {2{l_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wd_al = l_wdata;
      end
    endcase
  end

  // Load lane extraction and extension; words ignore sign_ext.
  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = l_addr[1] ? word[31:16] : word[15:0];
    case (l_size)
      2'b00:   ld = {{24{l_se & byte_v[7]}}, byte_v};
      2'b01:   ld = {{16{l_se & half_v[15]}}, half_v};
      default: ld = word;
    endcase
  end

  // RAM write on the edge leaving ACCESS; a reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && l_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd_al[8*k +: 8];
      end
    end
  end

  // Load result register; stores and faults leave it untouched.
  always_ff @(posedge clk) begin
    if (rst)                          rdata <= 32'd0;
    else if (state == ACCESS && !l_we) rdata <= ld;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-addressed reference memory
// predicts every completion; a monitor pops and compares on each done.
module tb_data_mem_ctrl;
  localparam int AW = 10;
  localparam int WC = 2;
  localparam int MB = 4 * (1 << AW);

  logic        clk = 1'b0;
  logic        rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, addr_err;
  logic [31:0] rdata;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  mb [MB];
  logic [31:0] last_rd = 32'd0;
  int          checks = 0;
  int          failures = 0;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: little-endian byte memory, access of 2^size bytes, must be
  // naturally aligned; loads extend from the top bit of the fetched width.
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic se,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nb, base;
    logic [31:0] v;
    nb    = 1 << sz;
    e.err = (sz == 2'd3) || ((a % nb) != 0);
    e.rd  = last_rd;
    if (!e.err) begin
      base = int'(a % MB);
      if (w) begin
        for (int i = 0; i < nb; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
        if (se && nb < 4 && v[8*nb-1]) begin
          for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
        end
        last_rd = v;
        e.rd    = v;
      end
    end
    return e;
  endfunction

  // Issue one request at posedge+1, optionally pulse a stray store while busy,
  // and check busy/done timing; data is checked by the monitor.
  task automatic run(input logic w, input logic [1:0] sz, input logic se,
                     input logic [31:0] a, input logic [31:0] wd, input bit poke = 1'b0);
    exp_t e;
    int   n, bc, lat;
    e = model(w, sz, se, a, wd);
    q.push_back(e);
    req = 1'b1; we = w; size = sz; sign_ext = se; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (poke && n == 1) begin
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'hBAD0BAD0;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    lat = e.err ? 0 : WC + 1;
    chk("done_latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(bc), 32'(lat));
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_err && !done) begin
        checks++; failures++;
        $display("FAIL err_without_done actual=1 expected=0");
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          mon_e = q.pop_front();
          chk("addr_err", 32'(addr_err), 32'(mon_e.err));
          chk("rdata", rdata, mon_e.rd);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Define the test window (bytes 0..255) before any load reads it.
    for (int w = 0; w < 64; w++) run(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

    // Basic word round trip
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_0x10_literal", rdata, 32'h8899AABB);
    // Byte/half merge
    run(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    run(1'b1, 2'd0, 1'b0, 32'h21, 32'hFF);
    run(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234);
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("lw_0x20_literal", rdata, 32'h1234FF00);
    // Extension
    run(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    run(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    run(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    run(1'b1, 2'd1, 1'b0, 32'h24, 32'h8000);
    run(1'b0, 2'd1, 1'b1, 32'h24, 32'h0);
    chk("lh_0x24_literal", rdata, 32'hFFFF8000);
    // Faults
    run(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    run(1'b1, 2'd1, 1'b0, 32'h25, 32'hCAFE);
    run(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
    run(1'b0, 2'd3, 1'b0, 32'h28, 32'h0);
    run(1'b1, 2'd3, 1'b0, 32'h28, 32'h55);
    // Stray request while busy must not land
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    run(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    // Address wrap
    run(1'b1, 2'd2, 1'b0, 32'h1000, 32'h0A0B0C0D);
    run(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);

    // Randomised traffic, mostly back-to-back, with aliases and stray pokes
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
      run(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
          $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Reset during WAIT aborts the store
    run(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h30; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_err", 32'(addr_err), 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);
    last_rd = 32'd0;
    repeat (6) @(posedge clk);
    #1;
    run(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    chk("lw_0x30_literal", rdata, 32'h11223344);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
